uart_tx_buffer: RTL and testbench

- Consumer end of the core's UART write port: accepts 32-bit write strobes from the core's memory stage and keeps the low byte.
- Queues bytes in a small FIFO and serializes them onto a single TX line as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed clocks-per-bit rate.
- Sits at top level beside the core, driven directly by the core's UART data/write-enable outputs.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo.sv | 62 ++++++
 rtl/uart_tx_buffer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit buffer.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; the head entry is presented on dout whenever not empty.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned N = 1 << DEPTH;
  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(N);

  logic [WIDTH-1:0] r_mem [N];
  logic [DEPTH-1:0] r_wr_ptr;
  logic [DEPTH-1:0] r_rd_ptr;
  logic [DEPTH:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full/empty come from the pre-edge count, so a push while full is refused
  // even when a pop happens on the same edge.
  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte-wide write port feeding a FIFO and an 8N1 serializer with a
// registered TX line.
module uart_tx_buffer #(
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [31:0]    din,
  input  logic           we,
  input  logic           ovf_clr,
  output logic           txd,
  output logic           busy,
  output logic [DEPTH:0] fifo_count,
  output logic           fifo_full,
  output logic           overflow
);

  import uart_pkg::*;

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_t            r_state, w_state_n;
  logic [DIV_W-1:0]     r_div, w_div_n;
  logic [BIT_W-1:0]     r_bit, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_txd, w_txd_n;
  logic                 r_ovf;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_div_last;
  logic [DATA_BITS-1:0] w_head;
  logic [DEPTH:0]       w_count;
  logic                 w_din_unused;

  assign w_din_unused = ^din[31:8];

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (we),
    .pop   (w_pop),
    .din   (din[DATA_BITS-1:0]),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_div_last = (r_div == DIV_LAST);

  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_div_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_state_n = TX_START;
        end
      end
      TX_START: begin
        if (w_div_last) begin
          w_div_n   = '0;
          w_bit_n   = '0;
          w_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_div_last) begin
          w_div_n   = '0;
          w_shift_n = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_state_n = TX_STOP;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (w_div_last) begin
          w_div_n   = '0;
          w_state_n = TX_IDLE;
        end
      end
      default: begin
        w_div_n   = '0;
        w_state_n = TX_IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so txd changes on the same
  // edge as the state, keeping the output a pure flop.
  always_comb begin
    w_txd_n = 1'b1;
    case (w_state_n)
      TX_START: w_txd_n = 1'b0;
      TX_DATA:  w_txd_n = w_shift_n[0];
      default:  w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= TX_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_div   <= w_div_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_txd   <= w_txd_n;
      if (we && w_full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign txd        = r_txd;
  assign busy       = (r_state != TX_IDLE) | (w_count != '0);
  assign fifo_count = w_count;
  assign fifo_full  = w_full;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: frame-timeline reference model, vector table and
// directed corner sequences, then randomized traffic.
module tb_uart_tx_buffer;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned FIFO_N  = 1 << DEPTH;
  localparam int unsigned FRAME_CYC = 10 * CLK_DIV;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [31:0]    din = '0;
  logic           we = 1'b0;
  logic           ovf_clr = 1'b0;
  logic           txd;
  logic           busy;
  logic [DEPTH:0] fifo_count;
  logic           fifo_full;
  logic           overflow;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_buffer #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .we         (we),
    .ovf_clr    (ovf_clr),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a frame timeline (cycle offset into
  // a 10-bit {stop, data, start} pattern).
  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  int         m_pos = 0;
  logic [9:0] m_frame = '1;
  logic       m_ovf = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    logic full_b, do_pop;
    if (!reset_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_frame  = '1;
      m_ovf    = 1'b0;
    end else begin
      full_b = (m_q.size() == FIFO_N);
      do_pop = !m_active && (m_q.size() > 0);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME_CYC) m_active = 1'b0;
      end
      if (do_pop) begin
        m_frame  = {1'b1, m_q.pop_front(), 1'b0};
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (we && !full_b) m_q.push_back(din[7:0]);
      if (we && full_b) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("m_txd",   32'(txd),        32'(m_active ? m_frame[m_pos / CLK_DIV] : 1'b1));
    chk("m_busy",  32'(busy),       32'(m_active || (m_q.size() > 0)));
    chk("m_count", 32'(fifo_count), 32'(m_q.size()));
    chk("m_full",  32'(fifo_full),  32'(m_q.size() == FIFO_N));
    chk("m_ovf",   32'(overflow),   32'(m_ovf));
  end

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       clr;
    int         cnt;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic frame_check(input logic [7:0] b, input string nm);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < int'(FRAME_CYC); k++) begin
      if (k > 0) @(negedge clk);
      chk(nm, 32'(txd), 32'(f[k / CLK_DIV]));
    end
  endtask

  task automatic wait_fall(input string nm);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(txd), 32'd0);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 3, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h66, 1'b0, 4, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'h99, 1'b1, 4, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b1};

    // Reset held with writes requested
    we  = 1'b1;
    din = 32'h0000_00AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_txd",   32'(txd),        32'd1);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovf",   32'(overflow),   32'd0);
    end
    we = 1'b0;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_txd",  32'(txd),  32'd1);

    // Single byte, latency and frame shape
    din = 32'hDEADBE55;
    we  = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("lat_pre", 32'(txd), 32'd1);
    @(negedge clk);
    chk("lat_fall", 32'(txd), 32'd0);
    frame_check(8'h55, "frame55");
    @(negedge clk);
    chk("busy_drop", 32'(busy), 32'd0);
    chk("idle_txd",  32'(txd),  32'd1);

    // Back-to-back frames
    din = 32'h0000_0001;
    we  = 1'b1;
    @(negedge clk);
    din = 32'hFFFF_FF80;
    @(negedge clk);
    we = 1'b0;
    wait_fall("b2b_fall");
    frame_check(8'h01, "frame01");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd === 1'b1 && n < 20);
    chk("b2b_gap", 32'(n - 1), 32'd1);
    frame_check(8'h80, "frame80");
    wait_idle("b2b_idle", 100);

    // Write path / overflow table
    foreach (tbl[i]) begin
      we      = tbl[i].we;
      din     = {24'hABCDEF, tbl[i].d};
      ovf_clr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i),  32'(fifo_full),  32'(tbl[i].full));
      chk($sformatf("tbl%0d_ovf", i),   32'(overflow),   32'(tbl[i].ovf));
    end
    we = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Write while full on the same edge the FSM pops
    n = 0;
    while (m_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fullpop_pre", 32'(fifo_count), 32'd4);
    din = 32'h0000_0077;
    we  = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("fullpop_count", 32'(fifo_count), 32'd3);
    chk("fullpop_ovf",   32'(overflow),   32'd1);

    // Asynchronous reset during data bit 3 of 0x22
    n = 0;
    while (!(m_active && (m_pos / CLK_DIV) == 4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pre_txd", 32'(txd), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_txd",   32'(txd),        32'd1);
    chk("mid_count", 32'(fifo_count), 32'd0);
    chk("mid_busy",  32'(busy),       32'd0);
    chk("mid_ovf",   32'(overflow),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = ((i / 500) % 3 == 0) ? 5 : (((i / 500) % 3 == 1) ? 60 : 95);
      we      = ($urandom_range(0, 99) < p);
      din     = $urandom;
      ovf_clr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end
    we = 1'b0;
    ovf_clr = 1'b0;
    wait_idle("drain_idle", 1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
